// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, detects
// load-use hazards (one-cycle bubble) and drives the EX operand-mux selects.
module id_ex_stage #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_use_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               exmem_valid,
  input  logic               exmem_reg_write,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic               memwb_valid,
  input  logic               memwb_reg_write,
  input  logic [REG_AW-1:0]  memwb_rd,
  input  logic [DATA_W-1:0]  memwb_wdata,
  input  logic               flush,
  input  logic               hold,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_use_imm,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [DATA_W-1:0]  ex_rdata2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               use_imm;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
    logic [REG_AW-1:0]  rd;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;
    logic [DATA_W-1:0]  imm;
  } ex_t;

  ex_t  ex_q, id_d, bub_d;
  logic lu, exmem_wr, memwb_wr;

  assign exmem_wr = exmem_valid & exmem_reg_write;
  assign memwb_wr = memwb_valid & memwb_reg_write;

  assign lu = ex_q.valid & ex_q.mem_read & ex_q.reg_write & id_valid &
              ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
               (id_use_rs2 & (id_rs2 == ex_q.rd)));

  assign stall = (lu | hold) & ~flush;

  // Normal load takes MEM/WB write-through so the register file bypass
  // is not needed for the cycle in which it is being written.
  always_comb begin
    id_d.valid     = id_valid;
    id_d.reg_write = id_reg_write;
    id_d.mem_read  = id_mem_read;
    id_d.mem_write = id_mem_write;
    id_d.use_imm   = id_use_imm;
    id_d.rs1       = id_rs1;
    id_d.rs2       = id_rs2;
    id_d.rd        = id_rd;
    id_d.alu_op    = id_alu_op;
    id_d.rdata1    = (memwb_wr && memwb_rd == id_rs1) ? memwb_wdata : id_rdata1;
    id_d.rdata2    = (memwb_wr && memwb_rd == id_rs2) ? memwb_wdata : id_rdata2;
    id_d.imm       = id_imm;
  end

  // Bubble: control cleared, data fields follow decode unmodified.
  always_comb begin
    bub_d           = id_d;
    bub_d.valid     = 1'b0;
    bub_d.reg_write = 1'b0;
    bub_d.mem_read  = 1'b0;
    bub_d.mem_write = 1'b0;
    bub_d.use_imm   = 1'b0;
    bub_d.rdata1    = id_rdata1;
    bub_d.rdata2    = id_rdata2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ex_q <= '0;
    else if (flush) ex_q <= '0;
    else if (!hold) ex_q <= lu ? bub_d : id_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_use_imm   = ex_q.use_imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_rdata1    = ex_q.rdata1;
  assign ex_rdata2    = ex_q.rdata2;
  assign ex_imm       = ex_q.imm;

  // EX/MEM is the younger writer, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_sel_a = 2'b00;
    if (exmem_wr && exmem_rd == ex_q.rs1)      fwd_sel_a = 2'b01;
    else if (memwb_wr && memwb_rd == ex_q.rs1) fwd_sel_a = 2'b10;
    fwd_sel_b = 2'b00;
    if (ex_q.use_imm)                          fwd_sel_b = 2'b11;
    else if (exmem_wr && exmem_rd == ex_q.rs2) fwd_sel_b = 2'b01;
    else if (memwb_wr && memwb_rd == ex_q.rs2) fwd_sel_b = 2'b10;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/priority sequences,
// then random stimulus against a behavioural pipeline-register model.
module tb_id_ex_stage;

  logic       clk, rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_mem_write, id_use_imm;
  logic [3:0] id_alu_op;
  logic [7:0] id_rdata1, id_rdata2, id_imm;
  logic       exmem_valid, exmem_reg_write, memwb_valid, memwb_reg_write;
  logic [2:0] exmem_rd, memwb_rd;
  logic [7:0] memwb_wdata;
  logic       flush, hold, stall;
  logic       ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm;
  logic [2:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  logic [7:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  id_ex_stage #(.DATA_W(8), .REG_AW(3), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_valid(memwb_valid), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_wdata(memwb_wdata), .flush(flush), .hold(hold), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_use_imm(ex_use_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs | writers (valid doubles as reg_write) | flush/hold | expectations
  typedef struct {
    int vld, rs1, rs2, u1, u2, rd, rw, mr, ui, rd1, rd2, imm;
    int xv, xrd, wv, wrd, wd;
    int fl, hd;
    int e_st, e_v, e_d1, chkf, e_fa, e_fb;
  } vec_t;

  typedef struct {
    logic       v, rw, mr, mw, ui;
    logic [2:0] rs1, rs2, rd;
    logic [3:0] op;
    logic [7:0] d1, d2, imm;
    logic       bub;
  } mst_t;

  vec_t tbl[19];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = 1'(t.vld); id_rs1 = 3'(t.rs1); id_rs2 = 3'(t.rs2);
    id_use_rs1 = 1'(t.u1); id_use_rs2 = 1'(t.u2); id_rd = 3'(t.rd);
    id_reg_write = 1'(t.rw); id_mem_read = 1'(t.mr); id_mem_write = 1'b0;
    id_use_imm = 1'(t.ui); id_alu_op = 4'h2;
    id_rdata1 = 8'(t.rd1); id_rdata2 = 8'(t.rd2); id_imm = 8'(t.imm);
    exmem_valid = 1'(t.xv); exmem_reg_write = 1'(t.xv); exmem_rd = 3'(t.xrd);
    memwb_valid = 1'(t.wv); memwb_reg_write = 1'(t.wv); memwb_rd = 3'(t.wrd);
    memwb_wdata = 8'(t.wd); flush = 1'(t.fl); hold = 1'(t.hd);
  endtask

  function automatic logic [1:0] ref_sel(input logic [2:0] rs);
    if (exmem_valid && exmem_reg_write && exmem_rd == rs) return 2'd1;
    if (memwb_valid && memwb_reg_write && memwb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  mst_t m, nx;
  logic lu;

  initial begin
    vec_t z;
    z = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0,0};
    tbl[0]  = '{1,2,3,1,1,1,1,0,0,'h10,'h20,0, 0,0,0,0,0,     0,0, 0,1,'h10,1,0,0};
    tbl[1]  = '{1,1,3,1,1,2,1,0,0,'h05,'h20,0, 1,1,0,0,0,     0,0, 0,1,'h05,1,1,0};
    tbl[2]  = '{1,0,0,1,0,4,1,1,1,'h00,'h00,8, 1,2,1,1,'h77,  0,0, 0,1,'h00,1,0,3};
    tbl[3]  = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 1,4,1,2,'h55,  0,0, 1,0,'h99,0,0,0};
    tbl[4]  = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 0,0,1,4,'h3C,  0,0, 0,1,'h3C,1,2,2};
    tbl[5]  = '{1,6,0,1,1,7,1,0,0,'h11,'h00,0, 1,2,1,6,'h3C,  0,0, 0,1,'h3C,1,2,0};
    tbl[6]  = '{1,1,2,1,1,3,1,0,0,'h21,'h00,0, 1,2,1,2,'h44,  0,0, 0,1,'h21,1,0,1};
    tbl[7]  = '{1,1,2,1,1,3,1,0,1,'h21,'h00,'h0F, 1,2,1,2,'h44, 0,0, 0,1,'h21,1,0,3};
    tbl[8]  = '{1,1,2,1,1,3,1,0,0,'h33,'h00,0, 0,0,0,0,0,     1,0, 0,0,'h00,1,0,0};
    tbl[9]  = '{1,0,0,1,0,4,1,1,1,'h00,'h00,8, 0,0,0,0,0,     0,0, 0,1,'h00,1,0,3};
    tbl[10] = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 0,0,0,0,0,     1,1, 0,0,'h00,1,0,0};
    tbl[11] = '{1,2,3,1,1,1,1,0,0,'h5A,'h20,0, 0,0,0,0,0,     0,0, 0,1,'h5A,1,0,0};
    for (int i = 12; i < 15; i++)
      tbl[i] = '{1,7,7,1,1,6,1,1,0,'hEE,'hEE,0, 0,0,0,0,0,    0,1, 1,1,'h5A,1,0,0};
    tbl[15] = '{1,0,0,1,0,4,1,1,1,'h00,'h00,8, 0,0,0,0,0,     0,0, 0,1,'h00,1,0,3};
    tbl[16] = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 0,0,0,0,0,     0,1, 1,1,'h00,1,0,3};
    tbl[17] = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 0,0,0,0,0,     0,0, 1,0,'h99,0,0,0};
    tbl[18] = '{1,4,4,1,1,5,1,0,0,'h99,'h99,0, 0,0,0,0,0,     0,0, 0,1,'h99,1,0,0};

    // reset state, with hold high so stall must follow it
    apply(z); hold = 1'b1; rst = 1'b1;
    #1;
    chk("reset regs", 64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm,
        ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_rdata1, ex_rdata2, ex_imm}), 64'd0);
    chk("reset fwd", 64'({fwd_sel_a, fwd_sel_b}), 64'd0);
    chk("reset stall=hold", 64'(stall), 64'd1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk); apply(tbl[i]); #1;
      chk($sformatf("v%0d stall", i), 64'(stall), 64'(tbl[i].e_st));
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
      chk($sformatf("v%0d ex_rdata1", i), 64'(ex_rdata1), 64'(tbl[i].e_d1));
      if (tbl[i].chkf != 0) begin
        chk($sformatf("v%0d fwd_a", i), 64'(fwd_sel_a), 64'(tbl[i].e_fa));
        chk($sformatf("v%0d fwd_b", i), 64'(fwd_sel_b), 64'(tbl[i].e_fb));
      end
    end

    // asynchronous reset mid-run, then first edge after release loads
    @(negedge clk); apply(tbl[0]); id_rdata1 = 8'hA5;
    @(posedge clk); #1;
    chk("pre-rst ex_valid", 64'(ex_valid), 64'd1);
    chk("pre-rst ex_rdata1", 64'(ex_rdata1), 64'hA5);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("async rst regs", 64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm,
        ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_rdata1, ex_rdata2, ex_imm}), 64'd0);
    chk("async rst fwd", 64'({fwd_sel_a, fwd_sel_b}), 64'd0);
    chk("async rst stall", 64'(stall), 64'd0);
    @(negedge clk); rst = 1'b0; apply(tbl[0]); id_rdata1 = 8'h42;
    @(posedge clk); #1;
    chk("post-rst ex_valid", 64'(ex_valid), 64'd1);
    chk("post-rst ex_rdata1", 64'(ex_rdata1), 64'h42);

    // random phase against the model
    @(negedge clk); rst = 1'b1; #2 rst = 1'b0;
    m = '{default: '0};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 3'($urandom); id_rs2 = 3'($urandom); id_rd = 3'($urandom);
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_reg_write = ($urandom_range(0, 3) != 0); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_use_imm = 1'($urandom); id_alu_op = 4'($urandom);
      id_rdata1 = 8'($urandom); id_rdata2 = 8'($urandom); id_imm = 8'($urandom);
      exmem_valid = 1'($urandom); exmem_reg_write = 1'($urandom); exmem_rd = 3'($urandom);
      memwb_valid = 1'($urandom); memwb_reg_write = 1'($urandom); memwb_rd = 3'($urandom);
      memwb_wdata = 8'($urandom);
      flush = ($urandom_range(0, 9) == 0); hold = ($urandom_range(0, 5) == 0);
      #1;
      lu = m.v & m.mr & m.rw & id_valid &
           ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
      chk($sformatf("r%0d stall", c), 64'(stall), 64'((lu || hold) && !flush));
      if (!m.bub) begin
        chk($sformatf("r%0d fwd_a", c), 64'(fwd_sel_a), 64'(ref_sel(m.rs1)));
        chk($sformatf("r%0d fwd_b", c), 64'(fwd_sel_b), 64'(m.ui ? 2'd3 : ref_sel(m.rs2)));
      end
      if (flush) nx = '{default: '0};
      else if (hold) nx = m;
      else begin
        nx = '{id_valid, id_reg_write, id_mem_read, id_mem_write, id_use_imm,
               id_rs1, id_rs2, id_rd, id_alu_op, id_rdata1, id_rdata2, id_imm, 1'b0};
        if (lu) begin
          {nx.v, nx.rw, nx.mr, nx.mw, nx.ui} = '0;
          nx.bub = 1'b1;
        end else begin
          if (memwb_valid && memwb_reg_write && memwb_rd == id_rs1) nx.d1 = memwb_wdata;
          if (memwb_valid && memwb_reg_write && memwb_rd == id_rs2) nx.d2 = memwb_wdata;
        end
      end
      @(posedge clk); #1;
      m = nx;
      chk($sformatf("r%0d regs", c),
          64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm,
               ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm}),
          64'({m.v, m.rw, m.mr, m.mw, m.ui, m.rs1, m.rs2, m.rd, m.d1, m.d2, m.imm}));
      if (m.v) chk($sformatf("r%0d alu_op", c), 64'(ex_alu_op), 64'(m.op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 8-bit pipelined core. It captures decoded operands and control from the decode stage and detects load-use hazards, inserting a single-cycle bubble when one occurs. It also generates the 2-bit forwarding selects that drive the two operand `MUX_4_1` instances at the EX-stage ALU inputs. Flush (taken branch) and downstream hold are resolved here.

## Interface
- `DATA_W`, 8, operand/result width
- `REG_AW`, 3, register address width (8 GPRs, all ordinary, no hardwired zero)
- `ALUOP_W`, 4, ALU opcode width
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rs1`, `id_rs2` in REG_AW: source register addresses.
- `id_use_rs1`, `id_use_rs2` in 1: instruction actually reads that source.
- `id_rd` in REG_AW: destination register.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_use_imm` in 1: control bits.
- `id_alu_op` in ALUOP_W: ALU operation.
- `id_rdata1`, `id_rdata2`, `id_imm` in DATA_W: register-file read data and immediate.
- `exmem_valid`, `exmem_reg_write` in 1; `exmem_rd` in REG_AW: EX/MEM writer.
- `memwb_valid`, `memwb_reg_write` in 1; `memwb_rd` in REG_AW; `memwb_wdata` in DATA_W: MEM/WB writer.
- `flush` in 1: taken branch; kill the instruction entering EX.
- `hold` in 1: downstream stall; freeze the stage.
- `stall` out 1: combinational; PC and IF/ID must not advance.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_use_imm` out 1: registered control.
- `ex_rs1`, `ex_rs2`, `ex_rd` out REG_AW; `ex_alu_op` out ALUOP_W.
- `ex_rdata1`, `ex_rdata2`, `ex_imm` out DATA_W: registered operands.
- `fwd_sel_a`, `fwd_sel_b` out 2: combinational operand mux selects.

## Operation
- Register update priority, per rising edge: `rst` > `flush` > `hold` > load-use bubble > normal load.
- `flush`: all control outputs go to 0, including `ex_valid`. Data fields are don't-care; they are cleared to 0.
- `hold`: every register keeps its value.
- Load-use hazard: `lu` = `ex_valid & ex_mem_read & ex_reg_write & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))`.
  - When `lu` is set, a bubble is loaded: control bits are cleared and data fields take the decode inputs.
- Normal load: all `id_*` fields are captured, with `ex_valid <= id_valid`.
- Write-through on normal load: if `memwb_valid & memwb_reg_write` and `memwb_rd == id_rs1`, then `ex_rdata1` captures `memwb_wdata` instead of `id_rdata1`. The same rule applies to `rs2`.
- `stall` = `(lu | hold) & ~flush`.
- Forward select A, first match wins:
  - `01` if `exmem_valid & exmem_reg_write & exmem_rd==ex_rs1`
  - `10` if the MEM/WB writer matches `ex_rs1`
  - otherwise `00` (`ex_rdata1`)
  - `fwd_sel_a` never drives `11`.
- Forward select B:
  - `11` if `ex_use_imm`
  - otherwise the same rule as A, applied to `ex_rs2`.
- Mux input mapping: `In0` = `ex_rdataN`, `In1` = EX/MEM ALU result, `In2` = `memwb_wdata`, `In3` = `ex_imm`.
- Forward selects are computed only from registered `ex_*` fields and the incoming writer ports; there are no feedback loops.

## Timing
- Reset (asynchronous, immediate): every registered output is 0, including `ex_valid`.
  - `fwd_sel_a` = `fwd_sel_b` = `00`, because `exmem_*`/`memwb_*` are also held in reset.
  - `stall` = `hold`.
- Latency: one cycle from `id_*` to `ex_*`.
- Load-use produces exactly one bubble. In the next cycle the load has moved to EX/MEM, so `lu` deasserts. The dependent instruction loads with `fwd_sel` = `10` one cycle later.
- `flush` and `lu` in the same cycle: a bubble is loaded and `stall` = 0.
- `flush` and `hold` in the same cycle: flush wins and the stage clears.
- `hold` and `lu` in the same cycle: the stage holds, `stall` = 1, and no bubble is inserted.
- Reset deasserting mid-pipeline: the first edge after release loads normally.

## Test plan
- Reset mid-run with `ex_valid`=1 and `ex_rdata1`=0xA5: all outputs read 0 immediately, before the next edge.
- Back-to-back ADD r1←…, then ADD r2←r1+r3: in the second instruction's EX cycle, with `exmem_rd`=1 and `exmem_reg_write`=1 → `fwd_sel_a`=`01` and `fwd_sel_b`=`00`.
- LOAD r4, then ADD r5←r4+r4:
  - `stall`=1 for exactly one cycle.
  - The next edge loads `ex_valid`=0.
  - Then the ADD is loaded with `fwd_sel_a`=`fwd_sel_b`=`10`.
- EX/MEM and MEM/WB both writing r2, with `ex_rs2`=2 and `ex_use_imm`=0 → `fwd_sel_b`=`01`. Setting `ex_use_imm`=1 → `fwd_sel_b`=`11`.
- Write-through: decode reads r6 with `id_rdata1`=0x11 while MEM/WB writes r6=0x3C → `ex_rdata1`=0x3C after the edge.
- Priority: `flush`, `hold` and `lu` all set together → next `ex_valid`=0 and `stall`=0. `hold` alone for 3 cycles → `ex_*` unchanged and `stall`=1 throughout.
